// File: rtl/gray_step_ctrl.sv
// gray_step_ctrl: command-driven sequencer for a Gray-code counter register.
// A command (cmd_steps, cmd_dir) is taken over a valid/ready handshake. The
// Gray count then advances by exactly that many single-bit steps. The run can
// be paused, and it can be aborted. A one-cycle done pulse ends each command.
// Optional feature: define GRAY_DOWN_EN to latch cmd_dir and allow down
// counting. Without it the counter is up-only and no decrement logic exists.
module gray_step_ctrl #(
  parameter int WIDTH = 3,
  parameter int STEPW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [STEPW-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic             pause,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [WIDTH-1:0] gray
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state, state_n;
  logic [WIDTH-1:0] gray_n;
  logic [STEPW-1:0] remaining, remaining_n;
  logic             aborted_n;
  logic             accept;

`ifdef GRAY_DOWN_EN
  logic dir, dir_n;
`else
  logic unused_dir;
  assign unused_dir = cmd_dir;
`endif

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

`ifdef GRAY_DOWN_EN
  function automatic logic [WIDTH-1:0] gray_step(input logic [WIDTH-1:0] g,
                                                 input logic down);
    logic [WIDTH-1:0] b;
    b = gray2bin(g);
    b = down ? (b - WIDTH'(1)) : (b + WIDTH'(1));
    return bin2gray(b);
  endfunction
`else
  function automatic logic [WIDTH-1:0] gray_step(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = gray2bin(g) + WIDTH'(1);
    return bin2gray(b);
  endfunction
`endif

  // The handshake uses the registered ready, so it stays low through reset.
  assign accept = cmd_valid & cmd_ready;

  // Next-state decode: accept, advance/pause/abort in RUN, and DONE -> IDLE.
  always_comb begin
    state_n     = state;
    gray_n      = gray;
    remaining_n = remaining;
    aborted_n   = aborted;
`ifdef GRAY_DOWN_EN
    dir_n       = dir;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          remaining_n = cmd_steps;
`ifdef GRAY_DOWN_EN
          dir_n       = cmd_dir;
`endif
          state_n     = (cmd_steps != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (abort) begin
          state_n   = DONE;
          aborted_n = 1'b1;
        end else if (!pause) begin
`ifdef GRAY_DOWN_EN
          gray_n      = gray_step(gray, dir);
`else
          gray_n      = gray_step(gray);
`endif
          remaining_n = remaining - STEPW'(1);
          if (remaining == STEPW'(1)) begin
            state_n = DONE;
          end
        end
      end
      DONE: begin
        state_n   = IDLE;
        aborted_n = 1'b0;
      end
      default: begin
        state_n   = IDLE;
        aborted_n = 1'b0;
      end
    endcase
  end

  // State/data registers. The status flags are registered from the next state,
  // so no input reaches an output combinationally and all flags are low in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gray      <= '0;
      remaining <= '0;
      aborted   <= 1'b0;
`ifdef GRAY_DOWN_EN
      dir       <= 1'b0;
`endif
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      gray      <= gray_n;
      remaining <= remaining_n;
      aborted   <= aborted_n;
`ifdef GRAY_DOWN_EN
      dir       <= dir_n;
`endif
      cmd_ready <= (state_n == IDLE);
      busy      <= (state_n == RUN);
      done      <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_gray_step_ctrl.sv
// Self-checking bench for gray_step_ctrl. It runs directed scenarios and then
// random commands. The reference model tracks an integer counter position.
// From that position and a remaining-step count it computes the expected Gray
// code, the done/aborted flags and the handshake behaviour.
module tb_gray_step_ctrl;
  localparam int WIDTH = 3;
  localparam int STEPW = 8;
  localparam int MOD   = 1 << WIDTH;
`ifdef GRAY_DOWN_EN
  localparam bit DOWN_OK = 1'b1;
`else
  localparam bit DOWN_OK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [STEPW-1:0] cmd_steps;
  logic             cmd_dir;
  logic             pause;
  logic             abort;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [WIDTH-1:0] gray;

  int n_checks = 0;
  int n_fail   = 0;
  int pos      = 0;

  always #5 clk = ~clk;

  gray_step_ctrl #(.WIDTH(WIDTH), .STEPW(STEPW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .pause(pause), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted), .gray(gray)
  );

  function automatic logic [WIDTH-1:0] exp_gray(int p);
    int m;
    m = ((p % MOD) + MOD) % MOD;
    return WIDTH'(m ^ (m >> 1));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(int steps, bit dir);
    cmd_valid = 1'b1;
    cmd_steps = STEPW'(steps);
    cmd_dir   = dir;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    pos = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({cmd_ready, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_hold: ready/busy/done=%b required 000", {cmd_ready, busy, done});
    end
    rst = 1'b0;
    tick();
    pos = 0;
    n_checks++;
    if (gray !== '0 || {cmd_ready, busy, done, aborted} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_state: gray=%b rbda=%b required gray=000 rbda=1000",
               gray, {cmd_ready, busy, done, aborted});
    end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] tbl [3];
    tbl = '{3'b001, 3'b011, 3'b010};
    issue(3, 1'b0);
    n_checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0 || gray !== 3'b000) begin
      n_fail++;
      $display("FAIL basic_accept: busy=%b ready=%b gray=%b required 1 0 000", busy, cmd_ready, gray);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      pos++;
      n_checks++;
      if (gray !== tbl[i] || done !== (i == 2)) begin
        n_fail++;
        $display("FAIL basic_step%0d: gray=%b done=%b required gray=%b done=%b",
                 i, gray, done, tbl[i], (i == 2));
      end
    end
    n_checks++;
    if (aborted !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: aborted=%b busy=%b required 0 0", aborted, busy);
    end
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle: ready=%b done=%b required 1 0", cmd_ready, done);
    end
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] tbl [8];
    logic [WIDTH-1:0] prev;
    tbl = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    do_reset();
    issue(8, 1'b0);
    prev = gray;
    for (int i = 0; i < 8; i++) begin
      tick();
      pos++;
      n_checks++;
      if (gray !== tbl[i] || $countones(gray ^ prev) != 1) begin
        n_fail++;
        $display("FAIL wrap_step%0d: gray=%b prev=%b required %b (one bit change)", i, gray, prev, tbl[i]);
      end
      n_checks++;
      if (done !== (i == 7)) begin
        n_fail++;
        $display("FAIL wrap_done%0d: done=%b required %b", i, done, (i == 7));
      end
      prev = gray;
    end
    tick();
  endtask

  task automatic test_pause();
    int  adv;
    int  lat;
    bit  p;
    adv = 0;
    lat = 0;
    issue(4, 1'b0);
    for (int j = 1; j <= 20 && adv < 4; j++) begin
      p = (j == 2 || j == 3);
      pause = p;
      tick();
      if (!p) begin
        pos++;
        adv++;
      end
      n_checks++;
      if (gray !== exp_gray(pos)) begin
        n_fail++;
        $display("FAIL pause_gray%0d: gray=%b required %b", j, gray, exp_gray(pos));
      end
      if (adv == 4) lat = j;
      n_checks++;
      if (done !== (adv == 4)) begin
        n_fail++;
        $display("FAIL pause_done%0d: done=%b required %b", j, done, (adv == 4));
      end
    end
    pause = 1'b0;
    n_checks++;
    if (lat != 6) begin
      n_fail++;
      $display("FAIL pause_latency: edges=%0d required 6", lat);
    end
    tick();
  endtask

  task automatic test_zero();
    logic [WIDTH-1:0] g0;
    g0 = gray;
    issue(0, 1'b0);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || gray !== g0 || aborted !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: done=%b busy=%b gray=%b aborted=%b required 1 0 %b 0",
               done, busy, gray, aborted, g0);
    end
    tick();
    n_checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_idle: ready=%b done=%b required 1 0", cmd_ready, done);
    end
  endtask

  task automatic test_abort();
    do_reset();
    issue(10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      pos++;
    end
    abort = 1'b1;
    pause = 1'b1;
    tick();
    abort = 1'b0;
    pause = 1'b0;
    n_checks++;
    if (gray !== 3'b010 || done !== 1'b1 || aborted !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_done: gray=%b done=%b aborted=%b required 010 1 1", gray, done, aborted);
    end
    tick();
    n_checks++;
    if (gray !== 3'b010 || aborted !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_idle: gray=%b aborted=%b ready=%b required 010 0 1", gray, aborted, cmd_ready);
    end
    issue(1, 1'b0);
    tick();
    pos++;
    n_checks++;
    if (gray !== 3'b110 || done !== 1'b1 || aborted !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_resume: gray=%b done=%b aborted=%b required 110 1 0", gray, done, aborted);
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    cmd_valid = 1'b1;
    cmd_steps = STEPW'(5);
    cmd_dir   = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      tick();
      pos++;
      n_checks++;
      if (gray !== exp_gray(pos) || cmd_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL midrun_step%0d: gray=%b ready=%b busy=%b required %b 0 1",
                 i, gray, cmd_ready, busy, exp_gray(pos));
      end
    end
    rst = 1'b1;
    cmd_valid = 1'b0;
    tick();
    pos = 0;
    n_checks++;
    if (gray !== '0 || {cmd_ready, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL midrun_reset: gray=%b rbd=%b required 000 000", gray, {cmd_ready, busy, done});
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || gray !== '0) begin
      n_fail++;
      $display("FAIL midrun_after: done=%b ready=%b gray=%b required 0 1 000", done, cmd_ready, gray);
    end
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1'b1;
    cmd_steps = STEPW'(2);
    cmd_dir   = 1'b0;
    tick();
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (i <= 2) pos++;
      n_checks++;
      if (cmd_ready !== (i == 3) || done !== (i == 2) || gray !== exp_gray(pos)) begin
        n_fail++;
        $display("FAIL b2b_edge%0d: ready=%b done=%b gray=%b required %b %b %b",
                 i, cmd_ready, done, gray, (i == 3), (i == 2), exp_gray(pos));
      end
    end
    tick();
    cmd_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0 || gray !== exp_gray(pos)) begin
      n_fail++;
      $display("FAIL b2b_reaccept: busy=%b ready=%b gray=%b required 1 0 %b", busy, cmd_ready, gray, exp_gray(pos));
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      pos++;
    end
    n_checks++;
    if (gray !== exp_gray(pos) || done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: gray=%b done=%b required %b 1", gray, done, exp_gray(pos));
    end
    tick();
  endtask

  task automatic test_down();
    logic [WIDTH-1:0] tbl [2];
    if (DOWN_OK) tbl = '{3'b100, 3'b101};
    else         tbl = '{3'b001, 3'b011};
    do_reset();
    issue(2, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      pos = pos + ((DOWN_OK) ? -1 : 1);
      n_checks++;
      if (gray !== tbl[i]) begin
        n_fail++;
        $display("FAIL down_step%0d: gray=%b required %b", i, gray, tbl[i]);
      end
    end
    tick();
  endtask

  task automatic test_random();
    int steps;
    int rem;
    int d;
    int cyc;
    bit dir;
    bit p;
    bit a;
    bit fin;
    for (int c = 0; c < 25; c++) begin
      pause = 1'($urandom_range(0, 1));
      abort = 1'($urandom_range(0, 1));
      tick();
      pause = 1'b0;
      abort = 1'b0;
      n_checks++;
      if (gray !== exp_gray(pos) || cmd_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rnd_idle%0d: gray=%b ready=%b required %b 1", c, gray, cmd_ready, exp_gray(pos));
      end
      steps = $urandom_range(0, 12);
      dir   = 1'($urandom_range(0, 1));
      d     = (dir && DOWN_OK) ? -1 : 1;
      issue(steps, dir);
      rem = steps;
      fin = (steps == 0);
      n_checks++;
      if (done !== fin || busy !== !fin) begin
        n_fail++;
        $display("FAIL rnd_accept%0d: done=%b busy=%b required %b %b", c, done, busy, fin, !fin);
      end
      cyc = 0;
      while (!fin && cyc < 60) begin
        p = ($urandom_range(0, 3) == 0);
        a = ($urandom_range(0, 15) == 0);
        pause = p;
        abort = a;
        tick();
        cyc++;
        if (a) begin
          fin = 1'b1;
          n_checks++;
          if (done !== 1'b1 || aborted !== 1'b1) begin
            n_fail++;
            $display("FAIL rnd_abort%0d: done=%b aborted=%b required 1 1", c, done, aborted);
          end
        end else begin
          if (!p) begin
            pos = pos + d;
            rem--;
          end
          fin = (rem == 0);
          n_checks++;
          if (done !== fin || busy !== !fin || (fin && aborted !== 1'b0)) begin
            n_fail++;
            $display("FAIL rnd_run%0d: done=%b busy=%b aborted=%b required %b %b 0",
                     c, done, busy, aborted, fin, !fin);
          end
        end
        n_checks++;
        if (gray !== exp_gray(pos)) begin
          n_fail++;
          $display("FAIL rnd_gray%0d: gray=%b required %b", c, gray, exp_gray(pos));
        end
      end
      pause = 1'b0;
      abort = 1'b0;
      if (!fin) begin
        n_checks++;
        n_fail++;
        $display("FAIL rnd_timeout%0d: no completion within 60 cycles, remaining=%0d required 0", c, rem);
        do_reset();
      end else begin
        tick();
        n_checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0 || aborted !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_end%0d: ready=%b done=%b aborted=%b required 1 0 0", c, cmd_ready, done, aborted);
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_steps = '0;
    cmd_dir   = 1'b0;
    pause     = 1'b0;
    abort     = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_wrap();
    test_pause();
    test_zero();
    test_abort();
    test_reset_midrun();
    test_back_to_back();
    test_down();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_step_ctrl.md
# gray_step_ctrl

Command-driven sequencer for a WIDTH-bit Gray-code counter register. It accepts a step command over a valid/ready handshake, advances the Gray count by exactly the requested number of steps (pausable, abortable), then pulses done. It sits between a control master (test sequencer or CPU-side register block) and any logic that consumes a single-bit-change position code.

## Interface
- WIDTH, 3: Gray counter width, ≥2
- STEPW, 8: step-count width, ≥1
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  controller can accept a command
- cmd_steps  in  STEPW  number of Gray steps to execute
- cmd_dir  in  1  0 = up, 1 = down (honoured only with GRAY_DOWN_EN)
- pause  in  1  freeze advancing while high
- abort  in  1  terminate the running command
- busy  out  1  command in progress (RUN state)
- done  out  1  one-cycle completion pulse
- aborted  out  1  qualifies done; 1 if the command ended by abort
- gray  out  WIDTH  registered Gray count

## Operation
- States:
  - IDLE: cmd_ready=1.
  - RUN: busy=1.
  - DONE: done=1, lasts one cycle.
- Reset (rst high at an edge): state=IDLE, gray=0, remaining=0, dir=0, aborted=0.
  - While rst is high, cmd_ready=0, busy=0, done=0.
  - rst overrides everything, including mid-RUN. No done pulse is issued for a command killed by reset.
- Accept: cmd_valid & cmd_ready at an edge. Latch remaining=cmd_steps and dir.
  - cmd_steps≠0 → RUN.
  - cmd_steps=0 → DONE directly; gray unchanged.
- Advancing in RUN, on each edge with pause=0 and abort=0:
  - gray ← bin2gray(gray2bin(gray) ± 1 mod 2^WIDTH).
  - remaining ← remaining−1.
  - If remaining was 1, go to DONE.
- Exactly one gray bit changes per advance. Wrap-around is seamless:
  - up: 100→000 (WIDTH=3)
  - down: 000→100
- pause=1 in RUN: gray and remaining hold; state stays RUN.
- abort=1 in RUN: go to DONE with aborted=1; gray holds (no advance that edge). Abort has priority over pause and over a final step.
- abort and pause are ignored outside RUN. cmd_valid is ignored outside IDLE.
- DONE → IDLE unconditionally on the next edge. aborted clears on leaving DONE.
- gray persists across commands; a new command continues from the current value.

## Timing
- Let edge k be the accept edge.
- cmd_steps=N≥1, no pause:
  - gray updates at edges k+1 … k+N.
  - done is high in the cycle after edge k+N.
  - cmd_ready is high again after edge k+N+1.
- Each pause cycle adds one cycle of latency.
- cmd_steps=0: done is high in the cycle after edge k; IDLE after edge k+1.
- All outputs are registered or decoded from state only; no input-to-output combinational path.
- Back-to-back: a new command can be accepted in the first IDLE cycle (edge k+N+2).

## Configuration
- GRAY_DOWN_EN defined: cmd_dir is latched on accept and selects up/down counting.
- GRAY_DOWN_EN undefined:
  - cmd_dir is ignored and the counter is up-only.
  - No decrement logic is built.

## Test plan
- **Reset:** after rst, expect gray=000, cmd_ready=1, busy=0, done=0. Accept steps=3, up, no pause → gray 001, 011, 010 at edges k+1..k+3; done=1, aborted=0 one cycle later.
- **Wrap:** from 000, steps=8 up → full sequence 001,011,010,110,111,101,100,000; check single-bit change every step; done after edge k+8.
- **Pause and zero steps:** steps=4 with pause high for 2 cycles mid-run → 4 advances total; done delayed by exactly 2 cycles. steps=0 → done at k+1, gray unchanged.
- **Abort:** steps=10, abort asserted with pause simultaneously after 3 advances → gray=010, done=1 with aborted=1, no further advance; next command continues from 010.
- **Reset mid-run:** steps=5, rst after 2 advances → gray=000, IDLE, no done pulse. cmd_valid held through RUN is not re-accepted until IDLE.
- **Down counting (GRAY_DOWN_EN):** from 000, steps=2, dir=1 → 100, 101. Without the macro, the same stimulus → 001, 011.
